// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
// Holds the FSM state encoding and the default bus widths.
package mem_port_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_CNT_W  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_I_BUSY = 2'd1,
        ARB_D_BUSY = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus bundle for mem_port_arbiter.
// master = the arbiter, slave = pipeline stages plus memory.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
);

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;
    logic              i_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              d_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_ack,
        output i_rdata, i_ready, i_stall,
        output d_rdata, d_ready, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_ack,
        input  i_rdata, i_ready, i_stall,
        input  d_rdata, d_ready, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_perf_cnt.sv
// Wait-cycle and starvation counters for mem_port_arbiter.
// Only built when MEM_ARB_PERF_CNT_EN is defined.
module mem_arb_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic        d_stall,
    input  logic        starve,
    output logic [31:0] perf_i_wait,
    output logic [31:0] perf_d_wait,
    output logic [31:0] perf_starve
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_i_wait <= '0;
            perf_d_wait <= '0;
            perf_starve <= '0;
        end else begin
            if (i_stall) perf_i_wait <= perf_i_wait + 32'd1;
            if (d_stall) perf_d_wait <= perf_d_wait + 32'd1;
            if (starve)  perf_starve <= perf_starve + 32'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch and LD/ST with bounded data bursts.
// Optional perf counters enabled by defining MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int MAX_D_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master bus
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_i_wait,
    output logic [31:0]        perf_d_wait,
    output logic [31:0]        perf_starve
`endif
);

    localparam logic [ARB_CNT_W-1:0] MAX_C = ARB_CNT_W'(MAX_D_BURST);

    arb_state_t           state, state_nx;
    logic [ARB_CNT_W-1:0] cnt, cnt_nx;
    logic                 req_q, req_nx;
    logic                 we_q, we_nx;
    logic [ADDR_W-1:0]    addr_q, addr_nx;
    logic [DATA_W-1:0]    wdata_q, wdata_nx;
    logic                 i_ready, d_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            cnt     <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            req_q   <= req_nx;
            we_q    <= we_nx;
            addr_q  <= addr_nx;
            wdata_q <= wdata_nx;
        end
    end

    // Data wins ties until it has taken MAX_D_BURST grants over a waiting fetch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        req_nx   = req_q;
        we_nx    = we_q;
        addr_nx  = addr_q;
        wdata_nx = wdata_q;
        unique case (state)
            ARB_IDLE: begin
                if (bus.d_req && (!bus.i_req || cnt < MAX_C)) begin
                    state_nx = ARB_D_BUSY;
                    req_nx   = 1'b1;
                    we_nx    = bus.d_we;
                    addr_nx  = bus.d_addr;
                    wdata_nx = bus.d_wdata;
                    cnt_nx   = bus.i_req ? cnt + 1'b1 : '0;
                end else if (bus.i_req) begin
                    state_nx = ARB_I_BUSY;
                    req_nx   = 1'b1;
                    we_nx    = 1'b0;
                    addr_nx  = bus.i_addr;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx   = '0;
                end
            end
            ARB_I_BUSY, ARB_D_BUSY: begin
                if (bus.mem_ack) begin
                    state_nx = ARB_IDLE;
                    req_nx   = 1'b0;
                end
            end
            default: begin
                state_nx = ARB_IDLE;
                req_nx   = 1'b0;
            end
        endcase
    end

    assign i_ready = bus.mem_ack & (state == ARB_I_BUSY);
    assign d_ready = bus.mem_ack & (state == ARB_D_BUSY);

    assign bus.i_ready   = i_ready;
    assign bus.d_ready   = d_ready;
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.i_stall   = bus.i_req & ~i_ready;
    assign bus.d_stall   = bus.d_req & ~d_ready;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
    logic starve;

    assign starve = (state == ARB_IDLE) & bus.i_req & bus.d_req
                  & (cnt == MAX_C);

    mem_arb_perf_cnt u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_stall     (bus.i_stall),
        .d_stall     (bus.d_stall),
        .starve      (starve),
        .perf_i_wait (perf_i_wait),
        .perf_d_wait (perf_d_wait),
        .perf_starve (perf_starve)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks for mem_port_arbiter.
// Random phase uses a memory/fairness reference model.
module tb_mem_port_arbiter;

    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_i_wait, perf_d_wait, perf_starve;
`endif

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_D_BURST (MAXB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_i_wait (perf_i_wait),
        .perf_d_wait (perf_d_wait),
        .perf_starve (perf_starve)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Reference state for the random phase
    logic [31:0] ext_mem [16];
    logic [31:0] shadow  [16];
    logic        prev_busy, prev_ack, prev_i, prev_d;
    logic        cur_busy, owner_i, ack, exp_ir, exp_dr;
    logic [31:0] snap_addr, snap_wdata, rdata;
    logic        snap_we;
    logic [3:0]  idx;
    int          dburst;
    int          g;

    initial begin
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk1("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk1("rst_i_stall", bus.i_stall, 1'b0);
        rst_n = 1'b1;

        // Single fetch, zero-wait memory
        @(negedge clk);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h100;
        #1;
        chk1("f0_i_stall", bus.i_stall, 1'b1);
        chk1("f0_mem_req", bus.mem_req, 1'b0);
        @(negedge clk);
        chk1("f1_mem_req", bus.mem_req, 1'b1);
        chk("f1_mem_addr", bus.mem_addr, 32'h100);
        chk1("f1_mem_we", bus.mem_we, 1'b0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        #1;
        chk1("f1_i_ready", bus.i_ready, 1'b1);
        chk("f1_i_rdata", bus.i_rdata, 32'hDEADBEEF);
        chk1("f1_i_stall", bus.i_stall, 1'b0);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.i_req   = 1'b0;
        #1;
        chk1("f2_mem_req", bus.mem_req, 1'b0);
        chk1("f2_i_ready", bus.i_ready, 1'b0);

        // Simultaneous requests: data store first, then fetch
        @(negedge clk);
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h300;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h200;
        bus.d_wdata = 32'h55;
        @(negedge clk);
        chk1("s1_mem_we", bus.mem_we, 1'b1);
        chk("s1_mem_wdata", bus.mem_wdata, 32'h55);
        chk("s1_mem_addr", bus.mem_addr, 32'h200);
        bus.mem_ack = 1'b1;
        #1;
        chk1("s1_d_ready", bus.d_ready, 1'b1);
        chk1("s1_i_stall", bus.i_stall, 1'b1);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        #1;
        chk1("s2_mem_req", bus.mem_req, 1'b0);
        @(negedge clk);
        chk1("s3_mem_req", bus.mem_req, 1'b1);
        chk("s3_mem_addr", bus.mem_addr, 32'h300);
        chk1("s3_mem_we", bus.mem_we, 1'b0);
        bus.mem_ack = 1'b1;
        #1;
        chk1("s3_i_ready", bus.i_ready, 1'b1);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.i_req   = 1'b0;

        // Reset in the middle of a data access
        @(negedge clk);
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h40;
        @(negedge clk);
        chk1("r_busy_mem_req", bus.mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("r_async_mem_req", bus.mem_req, 1'b0);
        bus.d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b1;
        #1;
        chk1("r_ack_d_ready", bus.d_ready, 1'b0);
        chk1("r_ack_i_ready", bus.i_ready, 1'b0);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        chk1("r_idle_mem_req", bus.mem_req, 1'b0);

        // Wait-state memory: ack on the sixth busy cycle
        @(negedge clk);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h80;
        #1;
        chk1("w0_d_stall", bus.d_stall, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk1("w_mem_req", bus.mem_req, 1'b1);
            chk("w_mem_addr", bus.mem_addr, 32'h80);
            chk1("w_mem_we", bus.mem_we, 1'b0);
            bus.mem_ack = (k == 6);
            #1;
            chk1("w_d_stall", bus.d_stall, k != 6);
            chk1("w_d_ready", bus.d_ready, k == 6);
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.d_req   = 1'b0;
        #1;
        chk1("w_end_mem_req", bus.mem_req, 1'b0);
`ifdef MEM_ARB_PERF_CNT_EN
        chk("w_perf_d_wait", perf_d_wait, 32'd6);
`endif

        // Starvation bound: pattern D D D D I repeating
        @(negedge clk);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h1000;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h2000;
        g = 0;
        for (int c = 0; c < 200 && g < 15; c++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_req) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = $urandom;
                #1;
                chk("starve_grant", bus.mem_addr,
                    (g % 5 == 4) ? 32'h1000 : 32'h2000);
                g++;
            end
        end
        chk("starve_grants_seen", g, 15);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        bus.mem_ack = 1'b0;
`ifdef MEM_ARB_PERF_CNT_EN
        chk("starve_perf", perf_starve, 32'd3);
`endif

        // Random traffic against a memory image and the fairness rule
        for (int k = 0; k < 16; k++) begin
            ext_mem[k] = $urandom;
            shadow[k]  = ext_mem[k];
        end
        @(negedge clk);
        prev_busy = 1'b0;
        prev_ack  = 1'b0;
        prev_i    = 1'b0;
        prev_d    = 1'b0;
        owner_i   = 1'b0;
        exp_ir    = 1'b0;
        exp_dr    = 1'b0;
        dburst    = 0;
        snap_addr = '0;
        snap_we   = 1'b0;
        snap_wdata = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            cur_busy = bus.mem_req;
            if (prev_busy) begin
                chk1("rnd_hold", cur_busy, !prev_ack);
                if (cur_busy) begin
                    chk("rnd_stable_addr", bus.mem_addr, snap_addr);
                    chk1("rnd_stable_we", bus.mem_we, snap_we);
                    chk("rnd_stable_wdata", bus.mem_wdata, snap_wdata);
                end
            end else begin
                if (!prev_i) dburst = 0;
                chk1("rnd_grant", cur_busy, prev_i | prev_d);
                if (cur_busy) begin
                    owner_i = prev_i && (!prev_d || dburst == MAXB);
                    if (owner_i) begin
                        chk("rnd_i_addr", bus.mem_addr, bus.i_addr);
                        chk1("rnd_i_we", bus.mem_we, 1'b0);
                        dburst = 0;
                    end else begin
                        chk("rnd_d_addr", bus.mem_addr, bus.d_addr);
                        chk1("rnd_d_we", bus.mem_we, bus.d_we);
                        if (bus.d_we)
                            chk("rnd_d_wdata", bus.mem_wdata, bus.d_wdata);
                        dburst = prev_i ? dburst + 1 : 0;
                    end
                    snap_addr  = bus.mem_addr;
                    snap_we    = bus.mem_we;
                    snap_wdata = bus.mem_wdata;
                end
            end

            if (exp_ir) bus.i_req = 1'b0;
            if (exp_dr) bus.d_req = 1'b0;
            if (!bus.i_req && $urandom_range(0, 2) == 0) begin
                bus.i_req  = 1'b1;
                bus.i_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!bus.d_req && $urandom_range(0, 2) == 0) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = 32'($urandom_range(0, 15)) << 2;
                bus.d_wdata = $urandom;
            end

            ack   = cur_busy ? ($urandom_range(0, 2) == 0)
                             : ($urandom_range(0, 4) == 0);
            rdata = $urandom;
            if (cur_busy && ack) begin
                idx = snap_addr[5:2];
                if (snap_we) ext_mem[idx] = snap_wdata;
                else         rdata = ext_mem[idx];
            end
            bus.mem_ack   = ack;
            bus.mem_rdata = rdata;
            #1;
            exp_ir = ack && cur_busy && owner_i;
            exp_dr = ack && cur_busy && !owner_i;
            chk1("rnd_i_ready", bus.i_ready, exp_ir);
            chk1("rnd_d_ready", bus.d_ready, exp_dr);
            chk1("rnd_i_stall", bus.i_stall, bus.i_req & ~exp_ir);
            chk1("rnd_d_stall", bus.d_stall, bus.d_req & ~exp_dr);
            if (exp_ir)
                chk("rnd_i_rdata", bus.i_rdata, shadow[bus.i_addr[5:2]]);
            if (exp_dr) begin
                if (bus.d_we) shadow[bus.d_addr[5:2]] = bus.d_wdata;
                else chk("rnd_d_rdata", bus.d_rdata, shadow[bus.d_addr[5:2]]);
            end
            prev_busy = cur_busy;
            prev_ack  = ack;
            prev_i    = bus.i_req;
            prev_d    = bus.d_req;
        end

        bus.i_req   = 1'b0;
        bus.d_req   = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported main-memory bus between the instruction-fetch requester and the data (LD/ST) requester of the Beta pipeline.
- Sequences each access through a request/acknowledge transaction with a variable-latency memory.
- Returns read data and completion to the winning requester, and generates the per-port stall signals consumed by the fetch and memory stages.
- Sits between the pipeline stages and the external memory interface.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- MAX_D_BURST, 4, maximum consecutive data grants while an instruction request waits (range 1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  instruction read request
- i_addr  in  ADDR_W  instruction address
- i_rdata  out  DATA_W  instruction read data
- i_ready  out  1  instruction transaction complete
- i_stall  out  1  fetch must hold
- d_req  in  1  data request
- d_we  in  1  data write enable (1 = store)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data
- d_ready  out  1  data transaction complete
- d_stall  out  1  memory stage must hold
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ack  in  1  memory transaction complete

Behaviour:
- FSM states: IDLE, I_BUSY, D_BUSY.
- Reset (rst_n low, asynchronous), all effective immediately:
  - state = IDLE, burst counter = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Reset mid-transaction abandons the access; any later mem_ack is ignored while in IDLE.
- Requester rules:
  - Hold req, addr, we and wdata stable from assertion until its ready pulse.
  - The cycle after ready, req reflects a new request.
- Arbitration happens only in IDLE:
  - d_req only → D_BUSY.
  - i_req only → I_BUSY.
  - Both, and burst counter < MAX_D_BURST → D_BUSY.
  - Both, and burst counter == MAX_D_BURST → I_BUSY.
  - Neither → stay IDLE.
- Burst counter:
  - Increments on each data grant made while i_req = 1.
  - Clears on an instruction grant.
  - Clears on any arbitration where i_req = 0.
  - Saturates at MAX_D_BURST.
- On the grant transition, register the winning port's addr/we/wdata onto the mem_* outputs and set mem_req = 1. Instruction grants force mem_we = 0.
- In *_BUSY: mem_req and the payload are held until mem_ack = 1. That cycle returns the FSM to IDLE and clears mem_req.
- Ready and read data:
  - i_ready = mem_ack & (state == I_BUSY); d_ready = mem_ack & (state == D_BUSY). Combinational, one-cycle pulses.
  - i_rdata and d_rdata pass mem_rdata through; valid only while the matching ready is high.
- Stalls: i_stall = i_req & ~i_ready; d_stall = d_req & ~d_ready.
- Latency: a request seen in IDLE at cycle 0 gives mem_req at cycle 1. Ready coincides with mem_ack, so with zero-wait memory (ack at cycle 1) the minimum is 2 cycles per access.
- Any mem_ack while in IDLE is ignored.
- A store's d_rdata content is undefined; d_ready still pulses.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, adds three 32-bit outputs, all reset to 0 and wrapping at 2^32:
  - perf_i_wait: counts cycles with i_stall = 1.
  - perf_d_wait: counts cycles with d_stall = 1.
  - perf_starve: counts forced instruction grants caused by burst counter == MAX_D_BURST.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package/defines file holds:
  - FSM state encoding constants (ARB_IDLE, ARB_I_BUSY, ARB_D_BUSY).
  - Default widths.
- One natural sub-module: mem_arb_perf_cnt, instantiated only under MEM_ARB_PERF_CNT_EN.
- FSM and datapath stay in the top module.

Test Plan:
- Reset mid-transaction: assert rst_n low while in D_BUSY → mem_req drops to 0 in the same cycle; an ack arriving after reset release produces no ready pulse.
- Single fetch, zero-wait memory: i_req = 1, i_addr = 0x100, ack the cycle after mem_req with rdata 0xDEADBEEF → mem_addr = 0x100 and mem_we = 0 at cycle 1; i_ready = 1 and i_rdata = 0xDEADBEEF at cycle 1; i_stall high only at cycle 0.
- Simultaneous requests: i_req = d_req = 1, d_we = 1, d_addr = 0x200, d_wdata = 0x55 → data granted first (mem_we = 1, mem_wdata = 0x55); instruction granted in the IDLE cycle after d_ready.
- Starvation bound: MAX_D_BURST = 4, d_req and i_req held continuously → exactly 4 data grants, then 1 instruction grant, repeating.
- Wait-state memory: mem_ack delayed 5 cycles → mem_req and payload stable for all 5 cycles; d_stall = 1 throughout; a single d_ready pulse.
- Perf counters (macro defined): the wait-state scenario gives perf_d_wait = 6 (includes the IDLE arbitration cycle), and the starvation run gives perf_starve incrementing once per forced instruction grant.
